zap_decode_skid_fifo: RTL and testbench

- Parametrised successor to the single-register compressed-decode pipeline stage.
- Sits between the predecoder (16/32-bit expansion) and the ARM decoder.
- Replaces the one-deep output register with a DEPTH-entry FIFO plus a registered output slot, so fetch can keep streaming while decode/issue stall.
- Keeps the codebase's clear/stall priority chain and adds valid/ready backpressure on the upstream side.

---
 rtl/zap_decode_skid_fifo_pkg.sv | 18 +
 rtl/zap_sync_fifo_mem.sv | 45 ++++
 rtl/zap_decode_skid_fifo.sv | 174 +++++++++++++++++
 tb/tb_zap_decode_skid_fifo.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_decode_skid_fifo_pkg.sv
// Shared constants for the compressed-decode skid FIFO stage.
package zap_decode_skid_fifo_pkg;

    // Stall/clear priority outcome, evaluated once per edge.
    localparam logic [1:0] PRIO_CLEAR = 2'd2;
    localparam logic [1:0] PRIO_HOLD  = 2'd1;
    localparam logic [1:0] PRIO_ADV   = 2'd0;

    // und, force32_align, iabort plus the 2-bit predictor state.
    localparam int unsigned FLAG_W = 5;

    // Width of one packed FIFO entry: instruction, two PCs, flags.
    function automatic int unsigned entry_w(input int unsigned instr_w,
                                            input int unsigned pc_w);
        return instr_w + 2 * pc_w + FLAG_W;
    endfunction

endpackage

// File: rtl/zap_sync_fifo_mem.sv
// Storage array with read/write pointers and an occupancy counter.
module zap_sync_fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Pointers wrap naturally; full/empty come from the count.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    // Entry storage; contents are don't-care after reset or flush.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/zap_decode_skid_fifo.sv
// Decode-side skid FIFO: stall/clear priority, bypass mux and output slot.
module zap_decode_skid_fifo
    import zap_decode_skid_fifo_pkg::*;
#(
    parameter int unsigned INSTR_W = 35,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned BYPASS  = 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_clear_from_writeback,
    input  logic                   i_data_stall,
    input  logic                   i_clear_from_alu,
    input  logic                   i_stall_from_shifter,
    input  logic                   i_stall_from_issue,
    input  logic                   i_stall_from_decode,
    input  logic                   i_clear_from_decode,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [INSTR_W-1:0]     i_instruction,
    input  logic                   i_und,
    input  logic                   i_force32_align,
    input  logic                   i_iabort,
    input  logic [1:0]             i_taken,
    input  logic [PC_W-1:0]        i_pc_ff,
    input  logic [PC_W-1:0]        i_pc_plus_8_ff,
    input  logic                   i_irq,
    input  logic                   i_fiq,
    output logic                   o_instruction_valid,
    output logic [INSTR_W-1:0]     o_instruction,
    output logic                   o_und,
    output logic                   o_force32_align,
    output logic                   o_iabort,
    output logic [1:0]             o_taken_ff,
    output logic [PC_W-1:0]        o_pc_ff,
    output logic [PC_W-1:0]        o_pc_plus_8_ff,
    output logic                   o_irq,
    output logic                   o_fiq,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned ENTRY_W = entry_w(INSTR_W, PC_W);
    localparam int unsigned CW      = $clog2(DEPTH) + 1;

    logic [1:0]         w_prio;
    logic               w_clear;
    logic               w_adv;
    logic               w_push;
    logic               w_pop;
    logic               w_bypass;
    logic               w_push_fifo;
    logic               w_empty;
    logic [CW-1:0]      w_count;
    logic [ENTRY_W-1:0] w_wdata;
    logic [ENTRY_W-1:0] w_head;

    logic [INSTR_W-1:0] w_head_instr;
    logic [PC_W-1:0]    w_head_pc;
    logic [PC_W-1:0]    w_head_pc8;
    logic               w_head_und;
    logic               w_head_f32;
    logic               w_head_iabort;
    logic [1:0]         w_head_taken;

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic               r_und;
    logic               r_f32;
    logic               r_iabort;
    logic [1:0]         r_taken;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_pc8;
    logic               r_irq;
    logic               r_fiq;

    // First-match priority chain across the pipeline's stall/clear sources.
    always_comb begin
        w_prio = PRIO_ADV;
        if (i_clear_from_writeback)      w_prio = PRIO_CLEAR;
        else if (i_data_stall)           w_prio = PRIO_HOLD;
        else if (i_clear_from_alu)       w_prio = PRIO_CLEAR;
        else if (i_stall_from_shifter)   w_prio = PRIO_HOLD;
        else if (i_stall_from_issue)     w_prio = PRIO_HOLD;
        else if (i_stall_from_decode)    w_prio = PRIO_HOLD;
        else if (i_clear_from_decode)    w_prio = PRIO_CLEAR;
    end

    assign w_clear     = (w_prio == PRIO_CLEAR);
    assign w_adv       = (w_prio == PRIO_ADV);
    assign w_empty     = (w_count == '0);
    assign o_ready     = i_reset_n && (w_count != CW'(DEPTH));
    assign w_push      = i_valid && o_ready && !w_clear;
    assign w_pop       = w_adv && !w_empty;
    assign w_bypass    = (BYPASS != 0) && w_adv && w_empty && w_push;
    assign w_push_fifo = w_push && !w_bypass;

    assign w_wdata = {i_instruction, i_pc_ff, i_pc_plus_8_ff,
                      i_und, i_force32_align, i_iabort, i_taken};
    assign {w_head_instr, w_head_pc, w_head_pc8,
            w_head_und, w_head_f32, w_head_iabort, w_head_taken} = w_head;

    zap_sync_fifo_mem #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_flush   (w_clear),
        .i_push    (w_push_fifo),
        .i_pop     (w_pop),
        .i_wdata   (w_wdata),
        .o_rdata   (w_head),
        .o_count   (w_count)
    );

    // Output slot: flush, hold, pop the head, bypass the input, or go idle.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || w_clear) begin
            r_valid  <= 1'b0;
            r_und    <= 1'b0;
            r_f32    <= 1'b0;
            r_iabort <= 1'b0;
            r_taken  <= 2'd0;
            r_irq    <= 1'b0;
            r_fiq    <= 1'b0;
        end else if (w_adv) begin
            if (w_pop) begin
                r_valid  <= 1'b1;
                r_instr  <= w_head_instr;
                r_pc     <= w_head_pc;
                r_pc8    <= w_head_pc8;
                r_und    <= w_head_und;
                r_f32    <= w_head_f32;
                r_iabort <= w_head_iabort;
                r_taken  <= w_head_taken;
                r_irq    <= i_irq;
                r_fiq    <= i_fiq;
            end else if (w_bypass) begin
                r_valid  <= 1'b1;
                r_instr  <= i_instruction;
                r_pc     <= i_pc_ff;
                r_pc8    <= i_pc_plus_8_ff;
                r_und    <= i_und;
                r_f32    <= i_force32_align;
                r_iabort <= i_iabort;
                r_taken  <= i_taken;
                r_irq    <= i_irq;
                r_fiq    <= i_fiq;
            end else begin
                r_valid  <= 1'b0;
                r_und    <= 1'b0;
                r_f32    <= 1'b0;
                r_iabort <= 1'b0;
                r_taken  <= 2'd0;
                r_irq    <= 1'b0;
                r_fiq    <= 1'b0;
            end
        end
    end

    assign o_instruction_valid = r_valid;
    assign o_instruction       = r_instr;
    assign o_und               = r_und;
    assign o_force32_align     = r_f32;
    assign o_iabort            = r_iabort;
    assign o_taken_ff          = r_taken;
    assign o_pc_ff             = r_pc;
    assign o_pc_plus_8_ff      = r_pc8;
    assign o_irq               = r_irq;
    assign o_fiq               = r_fiq;
    assign o_count             = w_count;

endmodule

// File: tb/tb_zap_decode_skid_fifo.sv
// Bench for the decode skid FIFO: a BYPASS=1 and a BYPASS=0 instance share stimulus.
module tb_zap_decode_skid_fifo;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [34:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic        und;
        logic        f32;
        logic        iabort;
        logic [1:0]  taken;
    } ent_t;

    typedef struct packed {
        logic valid;
        ent_t ent;
        logic irq;
        logic fiq;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic i_reset_n, i_clear_from_writeback, i_data_stall, i_clear_from_alu;
    logic i_stall_from_shifter, i_stall_from_issue, i_stall_from_decode, i_clear_from_decode;
    logic i_valid, i_und, i_force32_align, i_iabort, i_irq, i_fiq;
    logic [34:0] i_instruction;
    logic [1:0]  i_taken;
    logic [31:0] i_pc_ff, i_pc_plus_8_ff;

    logic        rdy0, val0, und0, f320, iab0, irq0, fiq0;
    logic [34:0] ins0;
    logic [1:0]  tk0;
    logic [31:0] pc0, pc80;
    logic [2:0]  cnt0;
    logic        rdy1, val1, und1, f321, iab1, irq1, fiq1;
    logic [34:0] ins1;
    logic [1:0]  tk1;
    logic [31:0] pc1, pc81;
    logic [2:0]  cnt1;

    zap_decode_skid_fifo #(.INSTR_W(35), .PC_W(32), .DEPTH(DEPTH), .BYPASS(1)) u0 (
        .i_clk(clk), .i_reset_n(i_reset_n),
        .i_clear_from_writeback(i_clear_from_writeback), .i_data_stall(i_data_stall),
        .i_clear_from_alu(i_clear_from_alu), .i_stall_from_shifter(i_stall_from_shifter),
        .i_stall_from_issue(i_stall_from_issue), .i_stall_from_decode(i_stall_from_decode),
        .i_clear_from_decode(i_clear_from_decode), .i_valid(i_valid), .o_ready(rdy0),
        .i_instruction(i_instruction), .i_und(i_und), .i_force32_align(i_force32_align),
        .i_iabort(i_iabort), .i_taken(i_taken), .i_pc_ff(i_pc_ff), .i_pc_plus_8_ff(i_pc_plus_8_ff),
        .i_irq(i_irq), .i_fiq(i_fiq), .o_instruction_valid(val0), .o_instruction(ins0),
        .o_und(und0), .o_force32_align(f320), .o_iabort(iab0), .o_taken_ff(tk0),
        .o_pc_ff(pc0), .o_pc_plus_8_ff(pc80), .o_irq(irq0), .o_fiq(fiq0), .o_count(cnt0));

    zap_decode_skid_fifo #(.INSTR_W(35), .PC_W(32), .DEPTH(DEPTH), .BYPASS(0)) u1 (
        .i_clk(clk), .i_reset_n(i_reset_n),
        .i_clear_from_writeback(i_clear_from_writeback), .i_data_stall(i_data_stall),
        .i_clear_from_alu(i_clear_from_alu), .i_stall_from_shifter(i_stall_from_shifter),
        .i_stall_from_issue(i_stall_from_issue), .i_stall_from_decode(i_stall_from_decode),
        .i_clear_from_decode(i_clear_from_decode), .i_valid(i_valid), .o_ready(rdy1),
        .i_instruction(i_instruction), .i_und(i_und), .i_force32_align(i_force32_align),
        .i_iabort(i_iabort), .i_taken(i_taken), .i_pc_ff(i_pc_ff), .i_pc_plus_8_ff(i_pc_plus_8_ff),
        .i_irq(i_irq), .i_fiq(i_fiq), .o_instruction_valid(val1), .o_instruction(ins1),
        .o_und(und1), .o_force32_align(f321), .o_iabort(iab1), .o_taken_ff(tk1),
        .o_pc_ff(pc1), .o_pc_plus_8_ff(pc81), .o_irq(irq1), .o_fiq(fiq1), .o_count(cnt1));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    ent_t q0[$];
    ent_t q1[$];
    exp_t ex [2];
    bit   live = 1'b0;

    function automatic ent_t cur_in();
        ent_t e;
        e.instr = i_instruction; e.pc = i_pc_ff; e.pc8 = i_pc_plus_8_ff;
        e.und = i_und; e.f32 = i_force32_align; e.iabort = i_iabort; e.taken = i_taken;
        return e;
    endfunction

    // 2 = flush, 1 = hold, 0 = advance; the first asserted source in rank order decides.
    function automatic int decide();
        if (i_clear_from_writeback) return 2;
        if (i_data_stall)           return 1;
        if (i_clear_from_alu)       return 2;
        if (i_stall_from_shifter || i_stall_from_issue || i_stall_from_decode) return 1;
        if (i_clear_from_decode)    return 2;
        return 0;
    endfunction

    task automatic model_step(input int k, input bit byp);
        ent_t tq[$];
        exp_t e;
        int   pr;
        bit   push;
        if (k == 0) tq = q0; else tq = q1;
        e = ex[k];
        if (!i_reset_n) begin
            tq.delete();
            e = '0;
        end else begin
            pr   = decide();
            push = i_valid && (tq.size() != DEPTH) && (pr != 2);
            if (pr == 2) begin
                tq.delete();
                e.valid = 0; e.ent.und = 0; e.ent.f32 = 0; e.ent.iabort = 0;
                e.irq = 0; e.fiq = 0;
            end else if (pr == 1) begin
                if (push) tq.push_back(cur_in());
            end else if (tq.size() != 0) begin
                e.ent = tq.pop_front();
                e.valid = 1; e.irq = i_irq; e.fiq = i_fiq;
                if (push) tq.push_back(cur_in());
            end else if (push && byp) begin
                e.ent = cur_in();
                e.valid = 1; e.irq = i_irq; e.fiq = i_fiq;
            end else begin
                if (push) tq.push_back(cur_in());
                e.valid = 0; e.ent.und = 0; e.ent.f32 = 0; e.ent.iabort = 0;
                e.irq = 0; e.fiq = 0;
            end
        end
        ex[k] = e;
        if (k == 0) q0 = tq; else q1 = tq;
    endtask

    always @(posedge clk) begin
        model_step(0, 1'b1);
        model_step(1, 1'b0);
        live = 1'b1;
    end

    // ---------------- compare process ----------------
    task automatic cmp(input int k, input logic rdy, input logic [2:0] cnt, input logic v,
                       input ent_t d, input logic irq, input logic fiq);
        int sz;
        sz = (k == 0) ? q0.size() : q1.size();
        chk($sformatf("u%0d_ready", k), 64'(rdy), 64'(i_reset_n && (sz != DEPTH)));
        chk($sformatf("u%0d_count", k), 64'(cnt), 64'(sz));
        chk($sformatf("u%0d_valid", k), 64'(v), 64'(ex[k].valid));
        chk($sformatf("u%0d_flags", k), 64'({d.und, d.f32, d.iabort, irq, fiq}),
            64'({ex[k].ent.und, ex[k].ent.f32, ex[k].ent.iabort, ex[k].irq, ex[k].fiq}));
        if (ex[k].valid) begin
            chk($sformatf("u%0d_instr", k), 64'(d.instr), 64'(ex[k].ent.instr));
            chk($sformatf("u%0d_pcs", k), {d.pc, d.pc8}, {ex[k].ent.pc, ex[k].ent.pc8});
            chk($sformatf("u%0d_taken", k), 64'(d.taken), 64'(ex[k].ent.taken));
        end
    endtask

    always @(negedge clk) begin
        if (live) begin
            cmp(0, rdy0, cnt0, val0, {ins0, pc0, pc80, und0, f320, iab0, tk0}, irq0, fiq0);
            cmp(1, rdy1, cnt1, val1, {ins1, pc1, pc81, und1, f321, iab1, tk1}, irq1, fiq1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        i_clear_from_writeback = 0; i_data_stall = 0; i_clear_from_alu = 0;
        i_stall_from_shifter = 0; i_stall_from_issue = 0; i_stall_from_decode = 0;
        i_clear_from_decode = 0; i_valid = 0; i_irq = 0; i_fiq = 0;
    endtask

    task automatic set_in(input logic [34:0] ins, input logic [31:0] pc);
        i_instruction = ins; i_pc_ff = pc; i_pc_plus_8_ff = pc + 32'd8;
        i_und = 0; i_force32_align = 0; i_iabort = 0; i_taken = 2'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        idle();
        set_in(35'h0, 32'h0);
        i_reset_n = 0;
        tick(); tick();
        chk("rst_valid", 64'(val0), 64'd0);
        chk("rst_taken", 64'(tk0), 64'd0);
        chk("rst_count", 64'(cnt1), 64'd0);
        chk("rst_ready", 64'(rdy0), 64'd0);
        i_reset_n = 1;
        #1;
        chk("rel_ready", 64'(rdy0), 64'd1);

        // 1: single push, bypass vs two-cycle path
        i_valid = 1; set_in(35'h1234, 32'h100);
        tick();
        chk("t1_valid0", 64'(val0), 64'd1);
        chk("t1_instr0", 64'(ins0), 64'h1234);
        chk("t1_pc0", 64'(pc0), 64'h100);
        chk("t1_count0", 64'(cnt0), 64'd0);
        chk("t1_valid1", 64'(val1), 64'd0);
        idle();
        tick();
        chk("t1_instr1", 64'(ins1), 64'h1234);
        tick(); tick();

        // 2: fill under issue stall, then drain in order
        i_stall_from_issue = 1; i_valid = 1;
        for (int i = 0; i < 6; i++) begin
            set_in(35'h200 + 35'(i), 32'h1000 + 32'(4 * i));
            tick();
            if (i == 3) begin
                chk("t2_full0", 64'({rdy0, cnt0}), 64'({1'b0, 3'd4}));
                chk("t2_full1", 64'({rdy1, cnt1}), 64'({1'b0, 3'd4}));
            end
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_drain0", 64'({val0, ins0}), 64'({1'b1, 35'h200 + 35'(i)}));
            chk("t2_drain1", 64'(ins1), 64'h200 + 64'(i));
        end
        tick();
        chk("t2_empty", 64'(val0), 64'd0);

        // 3: alu clear with simultaneous push
        i_stall_from_issue = 1; i_valid = 1;
        for (int i = 0; i < 3; i++) begin
            set_in(35'h300 + 35'(i), 32'h2000); tick();
        end
        i_clear_from_alu = 1; set_in(35'h3ff, 32'h2100);
        tick();
        chk("t3_clear0", 64'({val0, cnt0}), 64'd0);
        chk("t3_clear1", 64'({val1, cnt1}), 64'd0);
        idle(); tick(); tick();
        chk("t3_gone", 64'(val0), 64'd0);

        // 4: data_stall outranks alu clear; writeback clear outranks data_stall
        i_stall_from_issue = 1; i_valid = 1;
        for (int i = 0; i < 3; i++) begin
            set_in(35'h400 + 35'(i), 32'h3000); tick();
        end
        idle(); tick();
        i_data_stall = 1; i_clear_from_alu = 1;
        tick();
        chk("t4_hold_cnt", 64'(cnt0), 64'd2);
        chk("t4_hold_out", 64'({val0, ins0}), 64'({1'b1, 35'h400}));
        i_clear_from_alu = 0; i_clear_from_writeback = 1;
        tick();
        chk("t4_wb_flush", 64'({val0, cnt0, val1, cnt1}), 64'd0);
        idle(); tick();

        // 5: interrupt tags follow the advancing cycle, not the entry
        i_stall_from_issue = 1; i_valid = 1; set_in(35'h500, 32'h4000);
        tick();
        idle(); i_irq = 1;
        tick();
        chk("t5_irq_a", 64'({val0, irq0, irq1}), 64'b111);
        i_irq = 0; i_stall_from_issue = 1; i_valid = 1; set_in(35'h501, 32'h4004);
        tick();
        i_valid = 0;
        tick();
        chk("t5_irq_hold", 64'({irq0, irq1}), 64'b11);
        idle();
        tick();
        chk("t5_irq_b", 64'({val0, ins0, irq0}), 64'({1'b1, 35'h501, 1'b0}));
        tick();

        // 6: full-rate streaming with and without bypass
        idle(); i_valid = 1;
        for (int i = 0; i < 8; i++) begin
            set_in(35'h600 + 35'(i), 32'h5000 + 32'(4 * i));
            tick();
            chk("t6_cnt0", 64'(cnt0), 64'd0);
            chk("t6_cnt1", 64'(cnt1), 64'd1);
            if (i > 0) chk("t6_out1", 64'(ins1), 64'h600 + 64'(i - 1));
        end
        idle(); tick();
        chk("t6_last1", 64'({cnt1, ins1}), 64'({3'd0, 35'h607}));

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            i_reset_n              = ($urandom_range(0, 199) != 0);
            i_clear_from_writeback = ($urandom_range(0, 29) == 0);
            i_data_stall           = ($urandom_range(0, 9) == 0);
            i_clear_from_alu       = ($urandom_range(0, 19) == 0);
            i_stall_from_shifter   = ($urandom_range(0, 11) == 0);
            i_stall_from_issue     = ($urandom_range(0, 5) == 0);
            i_stall_from_decode    = ($urandom_range(0, 11) == 0);
            i_clear_from_decode    = ($urandom_range(0, 19) == 0);
            i_valid                = ($urandom_range(0, 3) != 0);
            i_instruction          = 35'({$urandom, $urandom});
            i_pc_ff                = $urandom;
            i_pc_plus_8_ff         = $urandom;
            i_und                  = 1'($urandom);
            i_force32_align        = 1'($urandom);
            i_iabort               = 1'($urandom);
            i_taken                = 2'($urandom);
            i_irq                  = 1'($urandom);
            i_fiq                  = 1'($urandom);
            tick();
        end
        i_reset_n = 1;
        idle();
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
